mult_div_seq: RTL

Iterative signed multiply/divide sequencer that owns the shared 32-iteration arithmetic engine behind the Hi/Lo registers of the multicycle CPU. The control unit issues a one-cycle `start` with an operation select. It then holds its wait state until `done`, after which it loads the Hi and Lo registers from this block's outputs. Operands come from the A and B registers.

---
 rtl/mult_div_seq.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mult_div_seq.sv
// mult_div_seq: iterative signed multiply/divide engine behind the Hi/Lo registers.
// One command at a time. The engine runs 32 iterations: Booth radix-2 for MULT
// and restoring division on magnitudes for DIV. Results and flags are registered.
// Handshake: a one-cycle start is accepted in IDLE or DONE. A start seen during
// RUN is dropped. done pulses for one cycle when hi/lo/div_zero become valid,
// and busy is high for exactly the RUN cycles.
module mult_div_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic        r_op;
    logic [31:0] r_acc;     // Booth accumulator / division partial remainder
    logic [31:0] r_q;       // multiplier shifting out / dividend-to-quotient
    logic        r_qm1;     // Booth q-1 bit
    logic [31:0] r_b;       // multiplicand / divisor magnitude
    logic        r_neg_q;
    logic        r_neg_r;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic        r_done;
    logic        r_dz;

    logic        w_accept;
    logic        w_div0;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_acc_ext;
    logic [32:0] w_b_ext;
    logic [32:0] w_sum;
    logic [31:0] w_m_acc_n;
    logic [31:0] w_m_q_n;
    logic [32:0] w_shift;
    logic [32:0] w_trial;
    logic        w_fits;
    logic [31:0] w_d_rem_n;
    logic [31:0] w_d_q_n;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_accept = start && (r_state != S_RUN);
    assign w_div0   = op && (b == 32'd0);
    // Magnitudes. 0x80000000 maps onto itself, which is the correct unsigned 2^31.
    assign w_a_mag  = a[31] ? (~a + 32'd1) : a;
    assign w_b_mag  = b[31] ? (~b + 32'd1) : b;

    // One Booth step. The 33-bit sum keeps the true sign when the multiplicand
    // is the most negative value. The shift keeps sum[32:1] and passes sum[0] into the multiplier.
    assign w_acc_ext = {r_acc[31], r_acc};
    assign w_b_ext   = {r_b[31], r_b};
    always_comb begin
        w_sum = w_acc_ext;
        case ({r_q[0], r_qm1})
            2'b10:   w_sum = w_acc_ext - w_b_ext;
            2'b01:   w_sum = w_acc_ext + w_b_ext;
            default: w_sum = w_acc_ext;
        endcase
    end
    assign w_m_acc_n = w_sum[32:1];
    assign w_m_q_n   = {w_sum[0], r_q[31:1]};

    // One restoring-division step. The partial remainder stays below the divisor,
    // which is at most 2^31, so the shifted value fits in 33 bits.
    assign w_shift   = {r_acc, r_q[31]};
    assign w_trial   = w_shift - {1'b0, r_b};
    assign w_fits    = ~w_trial[32];
    assign w_d_rem_n = w_fits ? w_trial[31:0] : w_shift[31:0];
    assign w_d_q_n   = {r_q[30:0], w_fits};
    assign w_quot    = r_neg_q ? (~w_d_q_n + 32'd1) : w_d_q_n;
    assign w_rem     = r_neg_r ? (~w_d_rem_n + 32'd1) : w_d_rem_n;

    // Control FSM, iteration datapath and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 6'd0;
            r_op    <= 1'b0;
            r_acc   <= 32'd0;
            r_q     <= 32'd0;
            r_qm1   <= 1'b0;
            r_b     <= 32'd0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    r_cnt <= r_cnt + 6'd1;
                    if (r_op) begin
                        r_acc <= w_d_rem_n;
                        r_q   <= w_d_q_n;
                    end else begin
                        r_acc <= w_m_acc_n;
                        r_q   <= w_m_q_n;
                        r_qm1 <= r_q[0];
                    end
                    if (r_cnt == 6'd31) begin
                        r_hi    <= r_op ? w_rem  : w_m_acc_n;
                        r_lo    <= r_op ? w_quot : w_m_q_n;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                    if (w_accept) begin
                        if (w_div0) begin
                            r_dz    <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_dz    <= 1'b0;
                            r_op    <= op;
                            r_cnt   <= 6'd0;
                            r_acc   <= 32'd0;
                            r_qm1   <= 1'b0;
                            r_q     <= op ? w_a_mag : a;
                            r_b     <= op ? w_b_mag : b;
                            r_neg_q <= a[31] ^ b[31];
                            r_neg_r <= a[31];
                            r_busy  <= 1'b1;
                            r_state <= S_RUN;
                        end
                    end
                end
            endcase
        end
    end

    assign hi        = r_hi;
    assign lo        = r_lo;
    assign busy      = r_busy;
    assign done      = r_done;
    assign div_zero  = r_dz;
    assign dbg_state = r_state;

endmodule
